gpio_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one GPIO register port (addr/wdata/we/re/rdata, combinational read data) among NREQ requesters, such as the CPU load/store unit, a debug module and a DMA engine. It issues at most one peripheral access per cycle. Per-requester SET/CLEAR operations run as atomic read-modify-write sequences. A registered response returns read data and write acknowledgements one cycle after each access completes.

---
 rtl/gpio_bus_arbiter_if.sv | 30 +++
 rtl/gpio_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_arbiter_if.sv
// Requester-side and peripheral-side signals of the GPIO register-port arbiter.
// The arbiter takes the slave view; the requester/peripheral environment takes the master view.
interface gpio_bus_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  localparam int unsigned DW = 32;

  logic [NREQ-1:0]      req_i;
  logic [2*NREQ-1:0]    op_i;
  logic [DW*NREQ-1:0]   addr_i;
  logic [DW*NREQ-1:0]   wdata_i;
  logic [NREQ-1:0]      gnt_o;
  logic [NREQ-1:0]      rvalid_o;
  logic [DW-1:0]        rdata_o;
  logic [DW-1:0]        per_addr_o;
  logic [DW-1:0]        per_wdata_o;
  logic                 per_we_o;
  logic                 per_re_o;
  logic [DW-1:0]        per_rdata_i;

  modport slave (
    input  req_i, op_i, addr_i, wdata_i, per_rdata_i,
    output gnt_o, rvalid_o, rdata_o, per_addr_o, per_wdata_o, per_we_o, per_re_o
  );

  modport master (
    output req_i, op_i, addr_i, wdata_i, per_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, per_addr_o, per_wdata_o, per_we_o, per_re_o
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO register port among NREQ requesters,
// with atomic SET/CLEAR read-modify-write and a registered one-cycle-late response.
module gpio_bus_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  gpio_bus_arbiter_if.slave  bus
);
  localparam int unsigned DW = 32;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  rmw_idx_q, rmw_idx_d;
  logic [DW-1:0]     rmw_addr_q, rmw_addr_d;
  logic [DW-1:0]     rmw_mask_q, rmw_mask_d;
  logic [DW-1:0]     rmw_old_q, rmw_old_d;
  logic              rmw_clr_q, rmw_clr_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [NREQ-1:0]   gnt_c;
  logic [DW-1:0]     per_addr_c, per_wdata_c;
  logic              per_we_c, per_re_c;

  logic [1:0]        op_arr    [NREQ];
  logic [DW-1:0]     addr_arr  [NREQ];
  logic [DW-1:0]     wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g]    = bus.op_i[2*g +: 2];
    assign addr_arr[g]  = bus.addr_i[DW*g +: DW];
    assign wdata_arr[g] = bus.wdata_i[DW*g +: DW];
  end

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
    return IDX_W'((32'(w) + 32'd1) % NREQ);
  endfunction

  // First asserted request at or after rr_ptr, wrapping around.
  logic              win_valid;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand;
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NREQ);
      if (!win_valid && bus.req_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next state and combinational port drive; everything is held quiet in reset.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rmw_idx_d   = rmw_idx_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_mask_d  = rmw_mask_q;
    rmw_old_d   = rmw_old_q;
    rmw_clr_d   = rmw_clr_q;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    gnt_c       = '0;
    per_addr_c  = '0;
    per_wdata_c = '0;
    per_we_c    = 1'b0;
    per_re_c    = 1'b0;
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            per_addr_c = addr_arr[win_idx];
            case (op_arr[win_idx])
              OP_READ: begin
                per_re_c          = 1'b1;
                gnt_c[win_idx]    = 1'b1;
                rvalid_d[win_idx] = 1'b1;
                rdata_d           = bus.per_rdata_i;
                rr_ptr_d          = next_ptr(win_idx);
              end
              OP_WRITE: begin
                per_we_c          = 1'b1;
                per_wdata_c       = wdata_arr[win_idx];
                gnt_c[win_idx]    = 1'b1;
                rvalid_d[win_idx] = 1'b1;
                rdata_d           = '0;
                rr_ptr_d          = next_ptr(win_idx);
              end
              OP_SET, OP_CLEAR: begin
                per_re_c   = 1'b1;
                rmw_idx_d  = win_idx;
                rmw_addr_d = addr_arr[win_idx];
                rmw_mask_d = wdata_arr[win_idx];
                rmw_clr_d  = (op_arr[win_idx] == OP_CLEAR);
                rmw_old_d  = bus.per_rdata_i;
                state_d    = RMW_WR;
              end
            endcase
          end
        end
        RMW_WR: begin
          // Completes from latched values even if the requester dropped req_i.
          per_we_c            = 1'b1;
          per_addr_c          = rmw_addr_q;
          per_wdata_c         = rmw_clr_q ? (rmw_old_q & ~rmw_mask_q) : (rmw_old_q | rmw_mask_q);
          gnt_c[rmw_idx_q]    = 1'b1;
          rvalid_d[rmw_idx_q] = 1'b1;
          rdata_d             = rmw_old_q;
          rr_ptr_d            = next_ptr(rmw_idx_q);
          state_d             = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      rmw_idx_q  <= '0;
      rmw_addr_q <= '0;
      rmw_mask_q <= '0;
      rmw_old_q  <= '0;
      rmw_clr_q  <= 1'b0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rmw_idx_q  <= rmw_idx_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_mask_q <= rmw_mask_d;
      rmw_old_q  <= rmw_old_d;
      rmw_clr_q  <= rmw_clr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.gnt_o       = gnt_c;
  assign bus.per_addr_o  = per_addr_c;
  assign bus.per_wdata_o = per_wdata_c;
  assign bus.per_we_o    = per_we_c;
  assign bus.per_re_o    = per_re_c;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.rdata_o     = rdata_q;
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: directed scenarios on a 2-requester instance, then fairness
// and a randomized run on a 4-requester instance against a transaction-level model.
module tb_gpio_bus_arbiter;
  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] CL = 2'b11;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  gpio_bus_arbiter_if #(.NREQ(2)) bus2 ();
  gpio_bus_arbiter_if #(.NREQ(4)) bus4 ();

  gpio_bus_arbiter #(.NREQ(2)) u_dut2 (.clk_i(clk), .rst_ni(rst_ni), .bus(bus2.slave));
  gpio_bus_arbiter #(.NREQ(4)) u_dut4 (.clk_i(clk), .rst_ni(rst_ni), .bus(bus4.slave));

  // Simple register files acting as the peripherals (read data is combinational).
  logic [31:0] mem2 [16];
  logic [31:0] mem4 [16];
  assign bus2.per_rdata_i = bus2.per_re_o ? mem2[bus2.per_addr_o[5:2]] : 32'h0;
  assign bus4.per_rdata_i = bus4.per_re_o ? mem4[bus4.per_addr_o[5:2]] : 32'h0;
  always @(posedge clk) if (bus2.per_we_o) mem2[bus2.per_addr_o[5:2]] <= bus2.per_wdata_o;
  always @(posedge clk) if (bus4.per_we_o) mem4[bus4.per_addr_o[5:2]] <= bus4.per_wdata_o;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set2(input int r, input logic rq, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] d);
    bus2.req_i[r]          = rq;
    bus2.op_i[2*r +: 2]    = op;
    bus2.addr_i[32*r +: 32]  = a;
    bus2.wdata_i[32*r +: 32] = d;
  endtask

  // Random-phase requester state and reference model.
  logic [3:0]  pend;
  logic [1:0]  t_op   [4];
  logic [31:0] t_addr [4];
  logic [31:0] t_wd   [4];
  logic [31:0] refm   [8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int          ptr_m, busy_w, exp_rv, nxt_rv, w, c;
    bit          busy_m;
    logic [31:0] busy_old, exp_rd, nxt_rd, nv;
    logic [3:0]  e_gnt;
    logic        e_re, e_we;
    logic [31:0] e_addr, e_wd;

    rst_ni = 1'b0;
    bus2.req_i = '0; bus2.op_i = '0; bus2.addr_i = '0; bus2.wdata_i = '0;
    bus4.req_i = '0; bus4.op_i = '0; bus4.addr_i = '0; bus4.wdata_i = '0;
    for (int i = 0; i < 16; i++) begin mem2[i] = '0; mem4[i] = '0; end

    // Outputs stay quiet in reset even with a request pending
    set2(0, 1'b1, RD, 32'h8, 32'h0);
    @(negedge clk); #1;
    chk("rst_gnt", 32'(bus2.gnt_o), 0);
    chk("rst_re", 32'(bus2.per_re_o), 0);
    chk("rst_we", 32'(bus2.per_we_o), 0);
    chk("rst_addr", bus2.per_addr_o, 0);
    chk("rst_rvalid", 32'(bus2.rvalid_o), 0);
    chk("rst_rdata", bus2.rdata_o, 0);
    @(negedge clk); rst_ni = 1'b1; set2(0, 1'b0, RD, 32'h0, 32'h0); #1;
    chk("idle_gnt", 32'(bus2.gnt_o), 0);
    chk("idle_re", 32'(bus2.per_re_o), 0);
    chk("idle_we", 32'(bus2.per_we_o), 0);

    // Single READ
    mem2[2] = 32'h5A;
    @(negedge clk); set2(0, 1'b1, RD, 32'h8, 32'h0); #1;
    chk("rd_re", 32'(bus2.per_re_o), 1);
    chk("rd_addr", bus2.per_addr_o, 32'h8);
    chk("rd_gnt", 32'(bus2.gnt_o), 32'b01);
    @(negedge clk); set2(0, 1'b0, RD, 32'h0, 32'h0); #1;
    chk("rd_rvalid", 32'(bus2.rvalid_o), 32'b01);
    chk("rd_rdata", bus2.rdata_o, 32'h5A);
    chk("rd_gnt_after", 32'(bus2.gnt_o), 0);

    // Contention: both WRITE, pointer freshly reset to 0
    @(negedge clk); rst_ni = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    set2(0, 1'b1, WR, 32'h10, 32'hAAAA_0000);
    set2(1, 1'b1, WR, 32'h14, 32'h0000_BBBB);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("cont_gnt", 32'(bus2.gnt_o), (i % 2 == 0) ? 32'b01 : 32'b10);
      chk("cont_we", 32'(bus2.per_we_o), 1);
      chk("cont_re", 32'(bus2.per_re_o), 0);
      if (i > 0) begin
        chk("cont_rvalid", 32'(bus2.rvalid_o), (i % 2 == 1) ? 32'b01 : 32'b10);
        chk("cont_rdata", bus2.rdata_o, 0);
      end
    end
    @(negedge clk); set2(0, 1'b0, WR, 0, 0); set2(1, 1'b0, WR, 0, 0); #1;
    chk("cont_rvalid_last", 32'(bus2.rvalid_o), 32'b10);
    chk("cont_mem0", mem2[4], 32'hAAAA_0000);
    chk("cont_mem1", mem2[5], 32'h0000_BBBB);

    // SET 0x0F | 0xF0 with a competing READ from req1
    mem2[3] = 32'h0F;
    @(negedge clk); set2(0, 1'b1, ST, 32'hC, 32'hF0); set2(1, 1'b1, RD, 32'hC, 0); #1;
    chk("set_rd_re", 32'(bus2.per_re_o), 1);
    chk("set_rd_we", 32'(bus2.per_we_o), 0);
    chk("set_rd_gnt", 32'(bus2.gnt_o), 0);
    chk("set_rd_addr", bus2.per_addr_o, 32'hC);
    @(negedge clk); #1;
    chk("set_wr_we", 32'(bus2.per_we_o), 1);
    chk("set_wr_re", 32'(bus2.per_re_o), 0);
    chk("set_wr_addr", bus2.per_addr_o, 32'hC);
    chk("set_wr_wdata", bus2.per_wdata_o, 32'hFF);
    chk("set_wr_gnt", 32'(bus2.gnt_o), 32'b01);
    @(negedge clk); set2(0, 1'b0, ST, 0, 0); #1;
    chk("set_comp_gnt", 32'(bus2.gnt_o), 32'b10);
    chk("set_comp_re", 32'(bus2.per_re_o), 1);
    chk("set_rvalid", 32'(bus2.rvalid_o), 32'b01);
    chk("set_rdata", bus2.rdata_o, 32'h0F);
    @(negedge clk); set2(1, 1'b0, RD, 0, 0); #1;
    chk("set_comp_rvalid", 32'(bus2.rvalid_o), 32'b10);
    chk("set_comp_rdata", bus2.rdata_o, 32'hFF);

    // CLEAR 0xFF & ~0x0F
    mem2[6] = 32'hFF;
    @(negedge clk); set2(0, 1'b1, CL, 32'h18, 32'h0F); #1;
    chk("clr_re", 32'(bus2.per_re_o), 1);
    @(negedge clk); #1;
    chk("clr_we", 32'(bus2.per_we_o), 1);
    chk("clr_wdata", bus2.per_wdata_o, 32'hF0);
    chk("clr_gnt", 32'(bus2.gnt_o), 32'b01);
    @(negedge clk); set2(0, 1'b0, CL, 0, 0); #1;
    chk("clr_rvalid", 32'(bus2.rvalid_o), 32'b01);
    chk("clr_rdata", bus2.rdata_o, 32'hFF);
    chk("clr_mem", mem2[6], 32'hF0);

    // Request dropped during the write half still completes
    mem2[8] = 32'h100;
    @(negedge clk); set2(0, 1'b1, ST, 32'h20, 32'h1); #1;
    chk("drop_re", 32'(bus2.per_re_o), 1);
    @(negedge clk); set2(0, 1'b0, ST, 32'h20, 32'h1); #1;
    chk("drop_gnt", 32'(bus2.gnt_o), 32'b01);
    chk("drop_we", 32'(bus2.per_we_o), 1);
    chk("drop_wdata", bus2.per_wdata_o, 32'h101);
    @(negedge clk); #1;
    chk("drop_rvalid", 32'(bus2.rvalid_o), 32'b01);
    chk("drop_rdata", bus2.rdata_o, 32'h100);

    // Reset hits the write half of a SET
    mem2[7] = 32'h0;
    @(negedge clk); set2(1, 1'b1, ST, 32'h1C, 32'h1); #1;
    chk("rstrmw_re", 32'(bus2.per_re_o), 1);
    chk("rstrmw_gnt0", 32'(bus2.gnt_o), 0);
    @(negedge clk); rst_ni = 1'b0; #1;
    chk("rstrmw_we", 32'(bus2.per_we_o), 0);
    chk("rstrmw_gnt", 32'(bus2.gnt_o), 0);
    chk("rstrmw_re2", 32'(bus2.per_re_o), 0);
    chk("rstrmw_addr", bus2.per_addr_o, 0);
    chk("rstrmw_wdata", bus2.per_wdata_o, 0);
    chk("rstrmw_rvalid", 32'(bus2.rvalid_o), 0);
    chk("rstrmw_rdata", bus2.rdata_o, 0);
    @(negedge clk); rst_ni = 1'b1;
    set2(0, 1'b1, RD, 32'h8, 0); set2(1, 1'b1, RD, 32'h1C, 0); #1;
    chk("rstrmw_first_gnt", 32'(bus2.gnt_o), 32'b01);
    @(negedge clk); set2(0, 1'b0, RD, 0, 0); #1;
    chk("rstrmw_second_gnt", 32'(bus2.gnt_o), 32'b10);
    chk("rstrmw_nowrite", mem2[7], 0);
    @(negedge clk); set2(1, 1'b0, RD, 0, 0); #1;
    chk("rstrmw_rvalid2", 32'(bus2.rvalid_o), 32'b10);

    // Four requesters: idle, then fairness
    @(negedge clk); rst_ni = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle4_gnt", 32'(bus4.gnt_o), 0);
      chk("idle4_re", 32'(bus4.per_re_o), 0);
      chk("idle4_we", 32'(bus4.per_we_o), 0);
      chk("idle4_addr", bus4.per_addr_o, 0);
    end
    @(negedge clk);
    bus4.req_i = 4'hF; bus4.op_i = '0;
    for (int r = 0; r < 4; r++) bus4.addr_i[32*r +: 32] = 32'(r * 4);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk("fair_gnt", 32'(bus4.gnt_o), 32'(1) << (i % 4));
      if (i > 0) chk("fair_rvalid", 32'(bus4.rvalid_o), 32'(1) << ((i - 1) % 4));
    end
    @(negedge clk); bus4.req_i = '0;

    // Randomized traffic against the model
    for (int i = 0; i < 8; i++) begin
      refm[i] = $urandom;
      mem4[i] = refm[i];
    end
    @(negedge clk); rst_ni = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    pend = '0; ptr_m = 0; busy_m = 1'b0; busy_w = 0; busy_old = '0;
    exp_rv = -1; exp_rd = '0;
    for (int r = 0; r < 4; r++) begin t_op[r] = RD; t_addr[r] = '0; t_wd[r] = '0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int r = 0; r < 4; r++) begin
        if (!pend[r] && cyc < 500 && $urandom_range(0, 2) == 0) begin
          pend[r]   = 1'b1;
          t_op[r]   = 2'($urandom_range(0, 3));
          t_addr[r] = 32'($urandom_range(0, 7) * 4);
          t_wd[r]   = $urandom;
        end
        bus4.op_i[2*r +: 2]     = t_op[r];
        bus4.addr_i[32*r +: 32]  = t_addr[r];
        bus4.wdata_i[32*r +: 32] = t_wd[r];
      end
      bus4.req_i = pend;
      #1;
      e_gnt = '0; e_re = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
      nxt_rv = -1; nxt_rd = '0;
      if (busy_m) begin
        nv = (t_op[busy_w] == ST) ? (busy_old | t_wd[busy_w]) : (busy_old & ~t_wd[busy_w]);
        e_we = 1'b1; e_addr = t_addr[busy_w]; e_wd = nv;
        e_gnt[busy_w] = 1'b1;
        refm[t_addr[busy_w][4:2]] = nv;
        nxt_rv = busy_w; nxt_rd = busy_old;
        ptr_m = (busy_w + 1) % 4;
        busy_m = 1'b0;
      end else begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          c = (ptr_m + k) % 4;
          if (w < 0 && pend[c]) w = c;
        end
        if (w >= 0) begin
          e_addr = t_addr[w];
          if (t_op[w] == RD) begin
            e_re = 1'b1; e_gnt[w] = 1'b1;
            nxt_rv = w; nxt_rd = refm[t_addr[w][4:2]];
            ptr_m = (w + 1) % 4;
          end else if (t_op[w] == WR) begin
            e_we = 1'b1; e_wd = t_wd[w]; e_gnt[w] = 1'b1;
            refm[t_addr[w][4:2]] = t_wd[w];
            nxt_rv = w; nxt_rd = '0;
            ptr_m = (w + 1) % 4;
          end else begin
            e_re = 1'b1;
            busy_m = 1'b1; busy_w = w; busy_old = refm[t_addr[w][4:2]];
          end
        end
      end
      chk("rand_gnt", 32'(bus4.gnt_o), 32'(e_gnt));
      chk("rand_re", 32'(bus4.per_re_o), 32'(e_re));
      chk("rand_we", 32'(bus4.per_we_o), 32'(e_we));
      chk("rand_addr", bus4.per_addr_o, e_addr);
      if (e_we) chk("rand_wdata", bus4.per_wdata_o, e_wd);
      chk("rand_rvalid", 32'(bus4.rvalid_o), (exp_rv >= 0) ? (32'(1) << exp_rv) : 32'(0));
      if (exp_rv >= 0) chk("rand_rdata", bus4.rdata_o, exp_rd);
      exp_rv = nxt_rv; exp_rd = nxt_rd;
      for (int r = 0; r < 4; r++) if (bus4.gnt_o[r]) pend[r] = 1'b0;
    end
    chk("rand_drain", 32'(pend), 0);
    for (int i = 0; i < 8; i++) chk("rand_mem", mem4[i], refm[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
